dcache_ctrl: RTL and testbench

//   Direct-mapped, write-through, no-write-allocate data cache with its refill/write FSM.

---
 rtl/dcache_ctrl_if.sv | 20 ++
 rtl/dcache_ctrl.sv | 157 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Memory-side bus of the data cache: one 32-bit word per req/ready transfer.
// The cache drives the request (master); main memory answers (slave).
interface dcache_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with refill/write FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  dcache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int TAG_W = 30 - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                        state_reg, state_next;
  logic [OFFSET_W-1:0]           count_reg, count_next;
  logic [LINES-1:0]              valid_reg;
  logic [TAG_W-1:0]              tag_mem  [LINES];
  logic [31:0]                   data_mem [LINES*WORDS];

  logic [OFFSET_W-1:0]           addr_word;
  logic [INDEX_W-1:0]            addr_index;
  logic [TAG_W-1:0]              addr_tag;
  logic [LINES-1:0]              line_sel;
  logic                          hit;
  logic [31:0]                   line_word;

  logic                          data_we;
  logic [INDEX_W+OFFSET_W-1:0]   data_waddr;
  logic [31:0]                   data_wdata;
  logic                          line_fill;
  logic                          line_inval;
  logic                          unused_byte_bits;

  assign addr_word        = addr[OFFSET_W+1:2];
  assign addr_index       = addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
  assign addr_tag         = addr[31:OFFSET_W+INDEX_W+2];
  assign unused_byte_bits = ^addr[1:0];
  assign line_sel         = {{(LINES-1){1'b0}}, 1'b1} << addr_index;
  assign hit              = valid_reg[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign line_word        = data_mem[{addr_index, addr_word}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    stall         = 1'b0;
    rdata         = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = {addr[31:2], 2'b00};
    mem.mem_wdata = wdata;
    data_we       = 1'b0;
    data_waddr    = {addr_index, addr_word};
    data_wdata    = wdata;
    line_fill     = 1'b0;
    line_inval    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MemWrite) begin
          // Store wins over a simultaneous load; only a hit touches the array.
          stall      = 1'b1;
          data_we    = hit;
          state_next = WRITE;
        end else if (MemRead) begin
          if (hit) begin
            rdata = line_word;
          end else begin
            stall      = 1'b1;
            count_next = '0;
            line_inval = 1'b1;
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {addr_tag, addr_index, count_reg, 2'b00};
        if (mem.mem_ready) begin
          data_we    = 1'b1;
          data_waddr = {addr_index, count_reg};
          data_wdata = mem.mem_rdata;
          count_next = count_reg + 1'b1;
          if (count_reg == {OFFSET_W{1'b1}}) begin
            line_fill  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        stall       = !mem.mem_ready;
        if (mem.mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is invalidated at refill start so an aborted refill never looks valid.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                            valid_reg[gi] <= 1'b0;
        else if (line_fill  && line_sel[gi]) valid_reg[gi] <= 1'b1;
        else if (line_inval && line_sel[gi]) valid_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (data_we)   data_mem[data_waddr] <= data_wdata;
    if (line_fill) tag_mem[addr_index]  <= addr_tag;
  end

`ifdef DCACHE_STATS_EN
  logic hit_event, miss_event;
  assign hit_event  = (state_reg == IDLE) && (MemWrite || MemRead) && hit;
  assign miss_event = (state_reg == IDLE) && (MemWrite || MemRead) && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_event  && hit_count  != 32'hFFFF_FFFF) hit_count  <= hit_count  + 1'b1;
      if (miss_event && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hand-computed loads/stores against a
// behavioural main memory with programmable ready latency.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .mem        (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Main memory: ready on the lat-th cycle of each transfer, 1 = back-to-back.
  logic [31:0] mem_arr [4096];
  int          lat  = 2;
  int          wcnt = 0;
  logic [31:0] rd_q [$];
  logic [31:0] wr_a_q [$];
  logic [31:0] wr_d_q [$];

  always @(negedge clk) begin
    if (!bus.mem_req) begin
      bus.mem_ready = 1'b0;
      wcnt          = 0;
    end else if (wcnt >= lat - 1) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_arr[bus.mem_addr[13:2]];
      wcnt          = 0;
    end else begin
      bus.mem_ready = 1'b0;
      wcnt++;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) begin
        wr_a_q.push_back(bus.mem_addr);
        wr_d_q.push_back(bus.mem_wdata);
        mem_arr[bus.mem_addr[13:2]] = bus.mem_wdata;
      end else begin
        rd_q.push_back(bus.mem_addr);
      end
    end
  end

  // One core access: hold the request until stall drops, then release after the edge.
  task automatic do_op(input string name, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_stalls, input logic [31:0] exp_rdata,
                       input int exp_rd, input int exp_wr);
    int   stalls = 0;
    int   we_err = 0;
    int   rd0    = rd_q.size();
    int   wr0    = wr_a_q.size();
    logic done   = 1'b0;
    logic [31:0] seen_rdata;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_req && (bus.mem_we !== wr)) we_err++;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk); #1;
    end
    seen_rdata = rdata;
    check({name, ".done"}, {31'd0, done}, 32'd1);
    check({name, ".stalls"}, stalls, exp_stalls);
    check({name, ".mem_we"}, we_err, 0);
    if (rd && !wr) check({name, ".rdata"}, seen_rdata, exp_rdata);
    @(negedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check({name, ".rd_xfers"}, rd_q.size() - rd0, exp_rd);
    check({name, ".wr_xfers"}, wr_a_q.size() - wr0, exp_wr);
    if (exp_wr > 0 && wr_a_q.size() > 0) begin
      check({name, ".wr_addr"}, wr_a_q[$], {a[31:2], 2'b00});
      check({name, ".wr_data"}, wr_d_q[$], d);
    end
    $display("op %-8s addr=%h rd=%0b wr=%0b stalls=%0d rdata=%h", name, a, rd, wr, stalls, seen_rdata);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hA000_0000 | i;
    mem_arr[16] = 32'h11;
    mem_arr[17] = 32'h22;
    mem_arr[18] = 32'h33;
    mem_arr[19] = 32'h44;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    rst      = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall",   {31'd0, stall},       32'd0);
    check("reset.rdata",   rdata,                32'd0);
    check("reset.mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("reset.mem_we",  {31'd0, bus.mem_we},  32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    lat = 2;
    do_op("rd40", 1, 0, 32'h40, 0, 9, 32'h11, 4, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) check("rd40.addr", rd_q[i], 32'h40 + 32'(4 * i));
    end
    do_op("rd48", 1, 0, 32'h48, 0, 0, 32'h33, 0, 0);

    lat = 3;
    do_op("wr44", 0, 1, 32'h44, 32'hDEAD_BEEF, 3, 0, 0, 1);
    do_op("rd44", 1, 0, 32'h44, 0, 0, 32'hDEAD_BEEF, 0, 0);

    lat = 2;
    do_op("wr1000", 0, 1, 32'h1000, 32'h1234_5678, 2, 0, 0, 1);
    do_op("rd1000", 1, 0, 32'h1000, 0, 9, 32'h1234_5678, 4, 0);

    lat = 1;
    do_op("rd840", 1, 0, 32'h840, 0, 5, 32'hA000_0210, 4, 0);
    lat = 2;
    do_op("rd40b", 1, 0, 32'h40, 0, 9, 32'h11, 4, 0);
    do_op("rd44b", 1, 0, 32'h44, 0, 0, 32'hDEAD_BEEF, 0, 0);

    // Reset while the second word of a refill is outstanding.
    r0       = rd_q.size();
    MemRead  = 1'b1;
    addr     = 32'h80;
    for (int i = 0; i < 50; i++) begin
      if (rd_q.size() > r0) break;
      @(negedge clk); #1;
    end
    check("rst.first_word", rd_q.size() - r0, 1);
    rst = 1'b1;
    #1;
    check("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk); #1;
`ifdef DCACHE_STATS_EN
    check("rst.hit_count",  hit_count,  32'd0);
    check("rst.miss_count", miss_count, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk); #1;
    do_op("rd40c", 1, 0, 32'h40, 0, 9, 32'h11, 4, 0);

    // Simultaneous load and store: the store wins and updates the hit line.
    do_op("rdwr40", 1, 1, 32'h40, 32'h55AA, 2, 0, 0, 1);
    do_op("rd40d", 1, 0, 32'h40, 0, 0, 32'h55AA, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
